// File: rtl/spi_cmd_sequencer.sv
// Frames SPI bytes into command packets (header, payload, optional checksum) and hands them out on valid/ready.
// Build option: CMD_CHECKSUM_EN adds the trailing XOR checksum byte and the CHECK state.
module spi_cmd_sequencer #(
   parameter int WIDTH          = 8,
   parameter int MAX_PAYLOAD    = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [WIDTH-1:0]             spi_data,
   input  logic                         spi_data_valid,
   output logic                         spi_clear,
   output logic [3:0]                   cmd_opcode,
   output logic [3:0]                   cmd_len,
   output logic [MAX_PAYLOAD*WIDTH-1:0] cmd_payload,
   output logic                         cmd_valid,
   input  logic                         cmd_ready,
   output logic                         err_length,
   output logic                         err_checksum,
   output logic                         err_timeout,
   output logic [7:0]                   err_count
);

   // state   | meaning
   // IDLE    | waiting for a header byte
   // PAYLOAD | collecting payload bytes, idx counts stored bytes
   // CHECK   | waiting for the checksum byte (CMD_CHECKSUM_EN only)
   // HOLD    | packet presented, input bytes left pending until handoff
`ifdef CMD_CHECKSUM_EN
   typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CHECK, S_HOLD} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_HOLD} state_t;
`endif

   localparam int              TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]      MAX_LEN  = 4'(MAX_PAYLOAD);
   localparam int              PW       = MAX_PAYLOAD * WIDTH;

   state_t           state_q, state_nxt;
   logic [3:0]       opcode_q, opcode_nxt;
   logic [3:0]       len_q, len_nxt;
   logic [PW-1:0]    payload_q, payload_nxt;
   logic [3:0]       idx_q, idx_nxt;
   logic [TW-1:0]    tmo_q, tmo_nxt;
   logic             err_len_q, err_len_nxt;
   logic             err_tmo_q, err_tmo_nxt;
   logic [7:0]       err_count_q;
   logic             err_any;
   logic             accept;
   logic [3:0]       hdr_len;
`ifdef CMD_CHECKSUM_EN
   logic [WIDTH-1:0] csum_q, csum_nxt;
   logic             err_ck_q, err_ck_nxt;
`endif

   // Reset also gates the clear so the SPI byte is never consumed while held in reset.
   assign accept    = reset & spi_data_valid & (state_q != S_HOLD);
   assign spi_clear = accept;
   assign hdr_len   = spi_data[3:0];

   always_comb begin
      state_nxt   = state_q;
      opcode_nxt  = opcode_q;
      len_nxt     = len_q;
      payload_nxt = payload_q;
      idx_nxt     = idx_q;
      tmo_nxt     = '0;
      err_len_nxt = 1'b0;
      err_tmo_nxt = 1'b0;
`ifdef CMD_CHECKSUM_EN
      csum_nxt    = csum_q;
      err_ck_nxt  = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               opcode_nxt  = spi_data[7:4];
               len_nxt     = hdr_len;
               payload_nxt = '0;
               idx_nxt     = '0;
`ifdef CMD_CHECKSUM_EN
               csum_nxt    = spi_data;
`endif
               if (hdr_len > MAX_LEN) begin
                  err_len_nxt = 1'b1;
               end else if (hdr_len == 4'd0) begin
`ifdef CMD_CHECKSUM_EN
                  state_nxt = S_CHECK;
`else
                  state_nxt = S_HOLD;
`endif
               end else begin
                  state_nxt = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (accept) begin
               payload_nxt[int'(idx_q)*WIDTH +: WIDTH] = spi_data;
               idx_nxt = idx_q + 4'd1;
`ifdef CMD_CHECKSUM_EN
               csum_nxt = csum_q ^ spi_data;
`endif
               if (idx_q == len_q - 4'd1) begin
`ifdef CMD_CHECKSUM_EN
                  state_nxt = S_CHECK;
`else
                  state_nxt = S_HOLD;
`endif
               end
            end else if (tmo_q == TMO_LAST) begin
               err_tmo_nxt = 1'b1;
               state_nxt   = S_IDLE;
            end else begin
               tmo_nxt = tmo_q + TW'(1);
            end
         end
`ifdef CMD_CHECKSUM_EN
         S_CHECK: begin
            if (accept) begin
               if (spi_data == csum_q) begin
                  state_nxt = S_HOLD;
               end else begin
                  err_ck_nxt = 1'b1;
                  state_nxt  = S_IDLE;
               end
            end else if (tmo_q == TMO_LAST) begin
               err_tmo_nxt = 1'b1;
               state_nxt   = S_IDLE;
            end else begin
               tmo_nxt = tmo_q + TW'(1);
            end
         end
`endif
         S_HOLD: begin
            if (cmd_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

`ifdef CMD_CHECKSUM_EN
   assign err_any = err_len_nxt | err_tmo_nxt | err_ck_nxt;
`else
   assign err_any = err_len_nxt | err_tmo_nxt;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         opcode_q    <= '0;
         len_q       <= '0;
         payload_q   <= '0;
         idx_q       <= '0;
         tmo_q       <= '0;
         err_len_q   <= 1'b0;
         err_tmo_q   <= 1'b0;
         err_count_q <= '0;
`ifdef CMD_CHECKSUM_EN
         csum_q      <= '0;
         err_ck_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_nxt;
         opcode_q    <= opcode_nxt;
         len_q       <= len_nxt;
         payload_q   <= payload_nxt;
         idx_q       <= idx_nxt;
         tmo_q       <= tmo_nxt;
         err_len_q   <= err_len_nxt;
         err_tmo_q   <= err_tmo_nxt;
         if (err_any && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
         end
`ifdef CMD_CHECKSUM_EN
         csum_q      <= csum_nxt;
         err_ck_q    <= err_ck_nxt;
`endif
      end
   end

   assign cmd_valid   = (state_q == S_HOLD);
   assign cmd_opcode  = opcode_q;
   assign cmd_len     = len_q;
   assign cmd_payload = payload_q;
   assign err_length  = err_len_q;
   assign err_timeout = err_tmo_q;
   assign err_count   = err_count_q;
`ifdef CMD_CHECKSUM_EN
   assign err_checksum = err_ck_q;
`else
   assign err_checksum = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Bench for spi_cmd_sequencer: queue-based packet model checked every cycle, plus directed literal checks.
module tb_spi_cmd_sequencer;
   localparam int MAXP = 4;
   localparam int TMO  = 16;
`ifdef CMD_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  spi_data = 8'h00;
   logic        spi_data_valid = 1'b0;
   logic        spi_clear;
   logic [3:0]  cmd_opcode, cmd_len;
   logic [31:0] cmd_payload;
   logic        cmd_valid;
   logic        cmd_ready = 1'b0;
   logic        err_length, err_checksum, err_timeout;
   logic [7:0]  err_count;

   int tests = 0;
   int fails = 0;
   bit rr_en = 1'b0;

   // model state: bytes of the open packet, the presented packet, pending pulses
   logic [7:0]  mq[$];
   bit          m_hold = 1'b0;
   int          m_sil = 0;
   logic [3:0]  m_op = '0, m_len = '0;
   logic [31:0] m_pl = '0;
   bit          m_el = 1'b0, m_ec = 1'b0, m_et = 1'b0;
   int          m_cnt = 0;

   spi_cmd_sequencer #(.WIDTH(8), .MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .spi_data(spi_data), .spi_data_valid(spi_data_valid),
      .spi_clear(spi_clear), .cmd_opcode(cmd_opcode), .cmd_len(cmd_len),
      .cmd_payload(cmd_payload), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .err_length(err_length), .err_checksum(err_checksum), .err_timeout(err_timeout),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int L;
      logic [7:0] x;
      if (!reset) begin
         mq.delete();
         m_hold = 0; m_sil = 0; m_op = '0; m_len = '0; m_pl = '0;
         m_el = 0; m_ec = 0; m_et = 0; m_cnt = 0;
         return;
      end
      m_el = 0; m_ec = 0; m_et = 0;
      if (m_hold) begin
         if (cmd_ready) m_hold = 0;
      end else if (spi_data_valid) begin
         mq.push_back(spi_data);
         m_sil = 0;
         L = int'(mq[0][3:0]);
         if (L > MAXP) begin
            m_el = 1;
            mq.delete();
         end else if (mq.size() == 1 + L + CK) begin
            x = '0;
            for (int i = 0; i < mq.size() - 1; i++) x ^= mq[i];
            if (CK == 0 || x == mq[mq.size()-1]) begin
               m_hold = 1;
               m_op = mq[0][7:4];
               m_len = mq[0][3:0];
               m_pl = '0;
               for (int i = 0; i < L; i++) m_pl[i*8 +: 8] = mq[1+i];
            end else begin
               m_ec = 1;
            end
            mq.delete();
         end
      end else if (mq.size() != 0) begin
         if (m_sil == TMO - 1) begin
            m_et = 1;
            mq.delete();
            m_sil = 0;
         end else begin
            m_sil++;
         end
      end
      if ((m_el || m_ec || m_et) && m_cnt < 255) m_cnt++;
   endtask

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         #1;
         check("spi_clear", spi_clear, reset && spi_data_valid && !m_hold);
         check("cmd_valid", cmd_valid, m_hold);
         check("err_length", err_length, m_el);
         check("err_checksum", err_checksum, m_ec);
         check("err_timeout", err_timeout, m_et);
         check("err_count", err_count, m_cnt);
         if (m_hold) begin
            check("cmd_opcode", cmd_opcode, m_op);
            check("cmd_len", cmd_len, m_len);
            check("cmd_payload", cmd_payload, m_pl);
         end
         model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rr_en) cmd_ready = 1'($urandom_range(0, 1));
      end
   end

   // Acts as the spi block: holds a byte until cleared, then drops valid for a cycle.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      spi_data = b;
      spi_data_valid = 1'b1;
      #1;
      while (!spi_clear && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      tests++;
      if (!spi_clear) begin
         fails++;
         $display("FAIL byte_accept: byte %0h not cleared within %0d cycles", b, n);
      end
      @(negedge clk);
      spi_data_valid = 1'b0;
      spi_data = 8'($urandom);
      @(negedge clk);
   endtask

   task automatic send_pkt(input logic [3:0] op, input logic [3:0] len, input logic [31:0] pl,
                           input bit bad, input int nsend);
      logic [7:0] b[$];
      logic [7:0] x;
      b.push_back({op, len});
      x = {op, len};
      for (int i = 0; i < int'(len) && i < MAXP; i++) begin
         b.push_back(pl[i*8 +: 8]);
         x ^= pl[i*8 +: 8];
      end
`ifdef CMD_CHECKSUM_EN
      b.push_back(bad ? (x ^ 8'h01) : x);
`else
      if (bad) x = '0;
`endif
      for (int i = 0; i < b.size() && i < nsend; i++) send_byte(b[i]);
   endtask

   task automatic check_presented(input string tag, input logic [3:0] op, input logic [3:0] len,
                                  input logic [31:0] pl);
      #1;
      check({tag, "_valid"}, cmd_valid, 1'b1);
      check({tag, "_opcode"}, cmd_opcode, op);
      check({tag, "_len"}, cmd_len, len);
      check({tag, "_payload"}, cmd_payload, pl);
      @(negedge clk);
      cmd_ready = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int n;
      int L, ns;
      // reset state, with a byte offered during reset
      spi_data = 8'h32;
      spi_data_valid = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_clear", spi_clear, 1'b0);
      check("rst_cmd_valid", cmd_valid, 1'b0);
      check("rst_err_count", err_count, 8'd0);
      check("rst_payload", cmd_payload, 32'd0);
      @(negedge clk);
      spi_data_valid = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // 1: good packet 0x32,0xA5,0x0F[,0x98]
      cmd_ready = 1'b0;
      send_pkt(4'h3, 4'h2, 32'h00000FA5, 1'b0, 99);
      check_presented("t1", 4'h3, 4'h2, 32'h00000FA5);
      #1;
      check("t1_released", cmd_valid, 1'b0);
      check("t1_err_count", err_count, 8'd0);
      @(negedge clk);

      // 2: bad checksum then a good packet
      send_pkt(4'h3, 4'h2, 32'h00000FA5, 1'b1, 99);
      #1;
      check("t2_err_count", err_count, 8'(CK));
      @(negedge clk);
      cmd_ready = 1'b0;
      send_pkt(4'h3, 4'h2, 32'h00000FA5, 1'b0, 99);
      check_presented("t2", 4'h3, 4'h2, 32'h00000FA5);

      // 3: oversize header, then a zero-length packet
      send_byte(8'h15);
      #1;
      check("t3_err_count", err_count, 8'(CK + 1));
      @(negedge clk);
      cmd_ready = 1'b0;
      send_pkt(4'h7, 4'h0, 32'h0, 1'b0, 99);
      check_presented("t3", 4'h7, 4'h0, 32'h0);

      // 4: timeout after 16 silent cycles in an open packet
      send_byte(8'h12);
      n = 0;
      while (n < 40) begin
         @(negedge clk);
         #1;
         n++;
         if (err_timeout) break;
      end
      check("t4_tmo_latency", n, 15);
      check("t4_err_count", err_count, 8'(CK + 2));
      @(negedge clk);
      cmd_ready = 1'b0;
      send_pkt(4'h3, 4'h0, 32'h0, 1'b0, 99);
      check_presented("t4", 4'h3, 4'h0, 32'h0);

      // max-length payload
      cmd_ready = 1'b0;
      send_pkt(4'hA, 4'h4, 32'hDEADBEEF, 1'b0, 99);
      check_presented("tmax", 4'hA, 4'h4, 32'hDEADBEEF);

      // 5: backpressure keeps the next header pending
      cmd_ready = 1'b0;
      send_pkt(4'h3, 4'h2, 32'h00000FA5, 1'b0, 99);
      spi_data = 8'h70;
      spi_data_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         check("t5_held_clear", spi_clear, 1'b0);
         @(negedge clk);
      end
      cmd_ready = 1'b1;
      #1;
      check("t5_handoff_cycle_clear", spi_clear, 1'b0);
      check("t5_handoff_valid", cmd_valid, 1'b1);
      @(negedge clk);
      #1;
      check("t5_next_accept", spi_clear, 1'b1);
      check("t5_valid_dropped", cmd_valid, 1'b0);
      @(negedge clk);
      spi_data_valid = 1'b0;
      @(negedge clk);
`ifdef CMD_CHECKSUM_EN
      send_byte(8'h70);
`endif
      repeat (2) @(negedge clk);

      // 6: reset mid-packet
      send_byte(8'h32);
      send_byte(8'hA5);
      reset = 1'b0;
      spi_data = 8'h0F;
      spi_data_valid = 1'b1;
      @(negedge clk);
      #1;
      check("t6_clear", spi_clear, 1'b0);
      check("t6_cmd_valid", cmd_valid, 1'b0);
      check("t6_err_count", err_count, 8'd0);
      check("t6_opcode", cmd_opcode, 4'h0);
      check("t6_len", cmd_len, 4'h0);
      check("t6_payload", cmd_payload, 32'h0);
      check("t6_errs", {err_length, err_checksum, err_timeout}, 3'b000);
      @(negedge clk);
      spi_data_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      send_pkt(4'h3, 4'h2, 32'h00000FA5, 1'b0, 99);
      check_presented("t6", 4'h3, 4'h2, 32'h00000FA5);

      // randomized packets with aborts, bad checksums and random backpressure
      rr_en = 1'b1;
      for (int k = 0; k < 300; k++) begin
         L = $urandom_range(0, 5);
         ns = (L > MAXP) ? 1 : 1 + L + CK;
         if (ns > 1 && $urandom_range(0, 9) == 0) begin
            send_pkt(4'($urandom), 4'(L), $urandom, 1'b0, $urandom_range(1, ns - 1));
            repeat (20) @(negedge clk);
         end else begin
            send_pkt(4'($urandom), 4'(L), $urandom, ($urandom_range(0, 3) == 0), ns);
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      rr_en = 1'b0;
      cmd_ready = 1'b1;
      repeat (3) @(negedge clk);

      // saturation of the error counter
      for (int k = 0; k < 270; k++) send_byte(8'hF5);
      #1;
      check("sat_err_count", err_count, 8'd255);
      @(negedge clk);
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
